// File: rtl/pc_select_predictor_pkg.sv
// Shared types and helpers for the next-PC source selector and its bimodal BHT.
package pc_select_predictor_pkg;

    // Next-PC source encoding shared by fetch and execute.
    typedef enum logic {
        PC_INPUT_PC_PLUS_4 = 1'b0,
        PC_INPUT_ALU       = 1'b1
    } pc_input_sel_t;

    // RV32 base opcodes seen at execute.
    typedef enum logic [6:0] {
        OPCODE_LOAD   = 7'b0000011,
        OPCODE_OP_IMM = 7'b0010011,
        OPCODE_AUIPC  = 7'b0010111,
        OPCODE_STORE  = 7'b0100011,
        OPCODE_OP     = 7'b0110011,
        OPCODE_LUI    = 7'b0110111,
        OPCODE_BRANCH = 7'b1100011,
        OPCODE_JALR   = 7'b1100111,
        OPCODE_JAL    = 7'b1101111,
        OPCODE_SYSTEM = 7'b1110011
    } opcode_t;

    // Width of the BHT index for a power-of-two table depth.
    function automatic int unsigned bht_idx_width(input int unsigned entries);
        return $clog2(entries);
    endfunction

    // Weakly not-taken: MSB clear, all lower bits set.
    function automatic int unsigned ctr_init_value(input int unsigned ctr_width);
        return (32'd1 << (ctr_width - 1)) - 32'd1;
    endfunction

endpackage

// File: rtl/pc_select_predictor_bht.sv
// Bimodal counter table: one async read port, one synchronous saturating
// increment/decrement write port, async reset to weakly not-taken.
module bht_counter_table
    import pc_select_predictor_pkg::*;
#(
    parameter int unsigned ENTRIES   = 64,
    parameter int unsigned CTR_WIDTH = 2,
    localparam int unsigned IdxW     = bht_idx_width(ENTRIES)
) (
    input  logic                 clk_i,
    input  logic                 reset_i,
    input  logic [IdxW-1:0]      rd_idx_i,
    output logic [CTR_WIDTH-1:0] rd_ctr_o,
    input  logic                 wr_en_i,
    input  logic [IdxW-1:0]      wr_idx_i,
    input  logic                 wr_taken_i
);

    localparam logic [CTR_WIDTH-1:0] CtrInit = CTR_WIDTH'(ctr_init_value(CTR_WIDTH));
    localparam logic [CTR_WIDTH-1:0] CtrMax  = '1;
    localparam logic [CTR_WIDTH-1:0] CtrMin  = '0;
    localparam logic [CTR_WIDTH-1:0] CtrOne  = CTR_WIDTH'(1);

    logic [CTR_WIDTH-1:0] ctr_q [ENTRIES];
    logic [CTR_WIDTH-1:0] wr_old;
    logic [CTR_WIDTH-1:0] wr_new;

    // Read port returns the stored value; no bypass from the write port.
    assign rd_ctr_o = ctr_q[rd_idx_i];

    // Saturating next value for the entry being trained.
    always_comb begin
        wr_old = ctr_q[wr_idx_i];
        wr_new = wr_old;
        if (wr_taken_i) begin
            if (wr_old != CtrMax) wr_new = wr_old + CtrOne;
        end else begin
            if (wr_old != CtrMin) wr_new = wr_old - CtrOne;
        end
    end

    // Counter storage; reset discards any update in flight.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            for (int i = 0; i < int'(ENTRIES); i++) begin
                ctr_q[i] <= CtrInit;
            end
        end else if (wr_en_i) begin
            ctr_q[wr_idx_i] <= wr_new;
        end
    end

endmodule

// File: rtl/pc_select_predictor.sv
// Next-PC source selector with bimodal branch prediction.
// Fetch gets a combinational prediction; execute resolves, trains the BHT and
// raises a registered one-cycle redirect on mispredict.
// Optional feature: define PC_SEL_PERF_COUNTERS_EN to build the branch and
// mispredict performance counters; otherwise both count ports are tied to 0.
module pc_select_predictor
    import pc_select_predictor_pkg::*;
#(
    parameter int unsigned XLEN        = 32,
    parameter int unsigned BHT_ENTRIES = 64,
    parameter int unsigned CTR_WIDTH   = 2
) (
    input  logic            clk_i,
    input  logic            reset_i,
    input  logic            fetch_valid_i,
    input  logic [XLEN-1:0] fetch_pc_i,
    output pc_input_sel_t   pred_pc_input_sel_o,
    input  logic            resolve_valid_i,
    input  opcode_t         resolve_opcode_i,
    input  logic [XLEN-1:0] resolve_pc_i,
    input  logic            resolve_pred_taken_i,
    input  logic            branch_result_i,
    output pc_input_sel_t   pc_input_sel_o,
    output logic            redirect_o,
    output logic [31:0]     branch_count_o,
    output logic [31:0]     mispredict_count_o
);

    localparam int unsigned IdxW = bht_idx_width(BHT_ENTRIES);

    logic [IdxW-1:0]      fetch_idx;
    logic [IdxW-1:0]      resolve_idx;
    logic [CTR_WIDTH-1:0] fetch_ctr;
    logic                 actual_taken;
    logic                 train_en;
    logic                 mispredict;
    pc_input_sel_t        pc_input_sel_d, pc_input_sel_q;
    logic                 redirect_q;

    // Word-aligned PCs: bits [1:0] never select an entry.
    assign fetch_idx   = fetch_pc_i[IdxW+1:2];
    assign resolve_idx = resolve_pc_i[IdxW+1:2];

    logic unused_pc_bits;
    assign unused_pc_bits = ^{fetch_pc_i[XLEN-1:IdxW+2], fetch_pc_i[1:0],
                              resolve_pc_i[XLEN-1:IdxW+2], resolve_pc_i[1:0]};

    bht_counter_table #(
        .ENTRIES   (BHT_ENTRIES),
        .CTR_WIDTH (CTR_WIDTH)
    ) u_bht (
        .clk_i      (clk_i),
        .reset_i    (reset_i),
        .rd_idx_i   (fetch_idx),
        .rd_ctr_o   (fetch_ctr),
        .wr_en_i    (train_en),
        .wr_idx_i   (resolve_idx),
        .wr_taken_i (branch_result_i)
    );

    // Fetch prediction: counter MSB, forced to PC+4 while in reset.
    always_comb begin
        pred_pc_input_sel_o = PC_INPUT_PC_PLUS_4;
        if (!reset_i && fetch_valid_i && fetch_ctr[CTR_WIDTH-1]) begin
            pred_pc_input_sel_o = PC_INPUT_ALU;
        end
    end

    // Resolve the real decision; only conditional branches train the table.
    always_comb begin
        actual_taken = 1'b0;
        train_en     = 1'b0;
        if (resolve_valid_i) begin
            case (resolve_opcode_i)
                OPCODE_BRANCH: begin
                    actual_taken = branch_result_i;
                    train_en     = 1'b1;
                end
                OPCODE_JAL, OPCODE_JALR: actual_taken = 1'b1;
                default:                 actual_taken = 1'b0;
            endcase
        end
        mispredict     = resolve_valid_i && (actual_taken != resolve_pred_taken_i);
        pc_input_sel_d = actual_taken ? PC_INPUT_ALU : PC_INPUT_PC_PLUS_4;
    end

    // Registered actual source and redirect pulse.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            pc_input_sel_q <= PC_INPUT_PC_PLUS_4;
            redirect_q     <= 1'b0;
        end else begin
            pc_input_sel_q <= pc_input_sel_d;
            redirect_q     <= mispredict;
        end
    end

    assign pc_input_sel_o = pc_input_sel_q;
    assign redirect_o     = redirect_q;

`ifdef PC_SEL_PERF_COUNTERS_EN
    logic [31:0] branch_count_q;
    logic [31:0] mispredict_count_q;

    // Wrapping performance counters, updated alongside the redirect register.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            branch_count_q     <= 32'd0;
            mispredict_count_q <= 32'd0;
        end else begin
            if (train_en)   branch_count_q     <= branch_count_q + 32'd1;
            if (mispredict) mispredict_count_q <= mispredict_count_q + 32'd1;
        end
    end

    assign branch_count_o     = branch_count_q;
    assign mispredict_count_o = mispredict_count_q;
`else
    assign branch_count_o     = 32'd0;
    assign mispredict_count_o = 32'd0;
`endif

endmodule
